// File: rtl/program_loader_if.sv
// rtl/program_loader_if.sv - byte stream, control and instruction-RAM write signals of the program loader
interface program_loader_if;
  logic        start;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        debug;
  logic        cpu_reset;
  logic        inst_ram_write_enable;
  logic [31:0] inst_ram_write_data;
  logic [31:0] inst_ram_write_address;
  logic        done;
  logic        error;

  modport master (
    output start, byte_valid, byte_data,
    input  byte_ready, debug, cpu_reset, inst_ram_write_enable,
    input  inst_ram_write_data, inst_ram_write_address, done, error
  );

  modport slave (
    input  start, byte_valid, byte_data,
    output byte_ready, debug, cpu_reset, inst_ram_write_enable,
    output inst_ram_write_data, inst_ram_write_address, done, error
  );
endinterface

// File: rtl/program_loader.sv
// rtl/program_loader.sv - loads a counted big-endian word stream into instruction RAM, then releases the CPU
module program_loader #(
  parameter logic [31:0] PC_INITIAL = 32'hbfc00000,
  parameter int          MAX_WORDS  = 1024
) (
  input  logic           clk,
  input  logic           reset,
  program_loader_if.slave bus
);
  localparam int CNT_W = $clog2(MAX_WORDS + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_DATA, S_WRITE, S_DONE, S_ERROR
  } state_t;

  state_t             r_state, w_state_n;
  logic [1:0]         r_idx, w_idx_n;
  logic [31:0]        r_hdr, w_hdr_n;
  logic [31:0]        r_word, w_word_n;
  logic [CNT_W-1:0]   r_cnt, w_cnt_n;
  logic [31:0]        r_addr, w_addr_n;
  logic [31:0]        r_wdata, w_wdata_n;
  logic               r_ready, r_wen, r_debug, r_cpu_reset, r_done, r_error;
  logic               w_xfer;
  logic [31:0]        w_hdr_shift;
  logic [31:0]        w_word_shift;

  assign w_xfer       = bus.byte_valid & r_ready;
  assign w_hdr_shift  = {r_hdr[23:0], bus.byte_data};
  assign w_word_shift = {r_word[23:0], bus.byte_data};

  always_comb begin
    w_state_n = r_state;
    w_idx_n   = r_idx;
    w_hdr_n   = r_hdr;
    w_word_n  = r_word;
    w_cnt_n   = r_cnt;
    w_addr_n  = r_addr;
    w_wdata_n = r_wdata;
    case (r_state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (bus.start) begin
          w_state_n = S_HDR;
          w_idx_n   = 2'd0;
          w_hdr_n   = 32'd0;
          w_addr_n  = PC_INITIAL;
        end
      end
      S_HDR: begin
        if (w_xfer) begin
          w_hdr_n = w_hdr_shift;
          w_idx_n = r_idx + 2'd1;
          if (r_idx == 2'd3) begin
            if (w_hdr_shift == 32'd0) begin
              w_state_n = S_DONE;
              w_addr_n  = PC_INITIAL;
            end else if (w_hdr_shift > 32'(MAX_WORDS)) begin
              w_state_n = S_ERROR;
            end else begin
              w_state_n = S_DATA;
              w_cnt_n   = w_hdr_shift[CNT_W-1:0];
            end
          end
        end
      end
      S_DATA: begin
        if (w_xfer) begin
          w_word_n = w_word_shift;
          w_idx_n  = r_idx + 2'd1;
          if (r_idx == 2'd3) begin
            w_state_n = S_WRITE;
            w_wdata_n = w_word_shift;
          end
        end
      end
      S_WRITE: begin
        w_cnt_n = r_cnt - CNT_W'(1);
        // The final write goes straight to DONE, which parks the address back at the boot PC.
        if (r_cnt == CNT_W'(1)) begin
          w_state_n = S_DONE;
          w_addr_n  = PC_INITIAL;
        end else begin
          w_state_n = S_DATA;
          w_addr_n  = r_addr + 32'd4;
        end
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they change in the same cycle as the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_idx       <= 2'd0;
      r_hdr       <= 32'd0;
      r_word      <= 32'd0;
      r_cnt       <= '0;
      r_addr      <= PC_INITIAL;
      r_wdata     <= 32'd0;
      r_ready     <= 1'b0;
      r_wen       <= 1'b0;
      r_debug     <= 1'b1;
      r_cpu_reset <= 1'b1;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_state     <= w_state_n;
      r_idx       <= w_idx_n;
      r_hdr       <= w_hdr_n;
      r_word      <= w_word_n;
      r_cnt       <= w_cnt_n;
      r_addr      <= w_addr_n;
      r_wdata     <= w_wdata_n;
      r_ready     <= (w_state_n == S_HDR) || (w_state_n == S_DATA);
      r_wen       <= (w_state_n == S_WRITE);
      r_debug     <= (w_state_n != S_DONE);
      r_cpu_reset <= (w_state_n != S_DONE);
      r_done      <= (w_state_n == S_DONE);
      r_error     <= (w_state_n == S_ERROR);
    end
  end

  assign bus.byte_ready             = r_ready;
  assign bus.debug                  = r_debug;
  assign bus.cpu_reset              = r_cpu_reset;
  assign bus.inst_ram_write_enable  = r_wen;
  assign bus.inst_ram_write_data    = r_wdata;
  assign bus.inst_ram_write_address = r_addr;
  assign bus.done                   = r_done;
  assign bus.error                  = r_error;
endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - directed vector bench for program_loader
module tb_program_loader;
  localparam logic [31:0] PC  = 32'hbfc00000;
  localparam logic [31:0] A4  = 32'hbfc00004;
  localparam logic [31:0] WPC = 32'hfffffffc;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  program_loader_if bus0 ();
  program_loader_if bus1 ();

  program_loader dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
  );

  program_loader #(.PC_INITIAL(WPC), .MAX_WORDS(1024)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        start;
    logic        valid;
    logic [7:0]  data;
    logic        e_ready;
    logic        e_wen;
    logic [31:0] e_wdata;
    logic [31:0] e_addr;
    logic        e_done;
    logic        e_err;
    logic        e_debug;
  } vec_t;

  vec_t vq[$];

  int          n_strobe0;
  logic [31:0] last_addr0;
  logic [31:0] last_data0;
  logic [31:0] addr_q1[$];
  logic [31:0] data_q1[$];

  always @(posedge clk) begin
    if (bus0.inst_ram_write_enable) begin
      n_strobe0  <= n_strobe0 + 1;
      last_addr0 <= bus0.inst_ram_write_address;
      last_data0 <= bus0.inst_ram_write_data;
    end
    if (bus1.inst_ram_write_enable) begin
      addr_q1.push_back(bus1.inst_ram_write_address);
      data_q1.push_back(bus1.inst_ram_write_data);
    end
  end

  function automatic vec_t mk(input logic s, input logic v, input logic [7:0] d,
                              input logic rdy, input logic wen, input logic [31:0] wd,
                              input logic [31:0] addr, input logic dn, input logic er,
                              input logic dbg);
    vec_t t;
    t.start = s; t.valid = v; t.data = d;
    t.e_ready = rdy; t.e_wen = wen; t.e_wdata = wd; t.e_addr = addr;
    t.e_done = dn; t.e_err = er; t.e_debug = dbg;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] flags0();
    return {26'd0, bus0.byte_ready, bus0.inst_ram_write_enable, bus0.done,
            bus0.error, bus0.debug, bus0.cpu_reset};
  endfunction

  function automatic logic [31:0] flags1();
    return {26'd0, bus1.byte_ready, bus1.inst_ram_write_enable, bus1.done,
            bus1.error, bus1.debug, bus1.cpu_reset};
  endfunction

  function automatic logic [31:0] exp_flags(input logic rdy, input logic wen, input logic dn,
                                            input logic er, input logic dbg);
    return {26'd0, rdy, wen, dn, er, dbg, dbg};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input int which);
    if (which == 0) bus0.start = 1'b1; else bus1.start = 1'b1;
    tick();
    bus0.start = 1'b0;
    bus1.start = 1'b0;
  endtask

  task automatic send_byte(input int which, input logic [7:0] b);
    logic rdy;
    logic got;
    got = 1'b0;
    for (int k = 0; k < 16 && !got; k++) begin
      if (which == 0) begin
        bus0.byte_valid = 1'b1; bus0.byte_data = b; rdy = bus0.byte_ready;
      end else begin
        bus1.byte_valid = 1'b1; bus1.byte_data = b; rdy = bus1.byte_ready;
      end
      tick();
      got = rdy;
    end
    bus0.byte_valid = 1'b0;
    bus1.byte_valid = 1'b0;
    check($sformatf("send_byte %0d accepted", which), {31'd0, got}, 32'd1);
  endtask

  task automatic send_word(input int which, input logic [31:0] w);
    for (int k = 3; k >= 0; k--) send_byte(which, w[8*k +: 8]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int strobes_before;
    n_checks = 0;
    n_errors = 0;
    n_strobe0 = 0;
    last_addr0 = 32'd0;
    last_data0 = 32'd0;
    bus0.start = 1'b0; bus0.byte_valid = 1'b0; bus0.byte_data = 8'd0;
    bus1.start = 1'b0; bus1.byte_valid = 1'b0; bus1.byte_data = 8'd0;
    reset = 1'b1;

    // two-word load, with start pulses that must be ignored in HDR, DATA and WRITE
    vq.push_back(mk(1,0,8'h00, 1,0,32'h0,PC,0,0,1));
    vq.push_back(mk(0,1,8'h00, 1,0,32'h0,PC,0,0,1));
    vq.push_back(mk(1,1,8'h00, 1,0,32'h0,PC,0,0,1));
    vq.push_back(mk(0,1,8'h00, 1,0,32'h0,PC,0,0,1));
    vq.push_back(mk(0,1,8'h02, 1,0,32'h0,PC,0,0,1));
    vq.push_back(mk(0,1,8'h20, 1,0,32'h0,PC,0,0,1));
    vq.push_back(mk(0,1,8'h0F, 1,0,32'h0,PC,0,0,1));
    vq.push_back(mk(0,1,8'h0A, 1,0,32'h0,PC,0,0,1));
    vq.push_back(mk(0,1,8'hF4, 0,1,32'h200F0AF4,PC,0,0,1));
    vq.push_back(mk(0,0,8'h00, 1,0,32'h0,A4,0,0,1));
    vq.push_back(mk(0,1,8'h20, 1,0,32'h0,A4,0,0,1));
    vq.push_back(mk(0,1,8'h18, 1,0,32'h0,A4,0,0,1));
    vq.push_back(mk(1,1,8'h00, 1,0,32'h0,A4,0,0,1));
    vq.push_back(mk(0,1,8'h08, 0,1,32'h20180008,A4,0,0,1));
    vq.push_back(mk(1,0,8'h00, 0,0,32'h0,PC,1,0,0));
    // zero-word header
    vq.push_back(mk(1,0,8'h00, 1,0,32'h0,PC,0,0,1));
    vq.push_back(mk(0,1,8'h00, 1,0,32'h0,PC,0,0,1));
    vq.push_back(mk(0,1,8'h00, 1,0,32'h0,PC,0,0,1));
    vq.push_back(mk(0,1,8'h00, 1,0,32'h0,PC,0,0,1));
    vq.push_back(mk(0,1,8'h00, 0,0,32'h0,PC,1,0,0));
    // header 1025 exceeds MAX_WORDS
    vq.push_back(mk(1,0,8'h00, 1,0,32'h0,PC,0,0,1));
    vq.push_back(mk(0,1,8'h00, 1,0,32'h0,PC,0,0,1));
    vq.push_back(mk(0,1,8'h00, 1,0,32'h0,PC,0,0,1));
    vq.push_back(mk(0,1,8'h04, 1,0,32'h0,PC,0,0,1));
    vq.push_back(mk(0,1,8'h01, 0,0,32'h0,PC,0,1,1));
    vq.push_back(mk(0,1,8'h55, 0,0,32'h0,PC,0,1,1));
    vq.push_back(mk(1,0,8'h00, 1,0,32'h0,PC,0,0,1));
    // toggled byte_valid, byte held across the WRITE cycle
    vq.push_back(mk(0,1,8'h00, 1,0,32'h0,PC,0,0,1));
    vq.push_back(mk(0,0,8'h00, 1,0,32'h0,PC,0,0,1));
    vq.push_back(mk(0,1,8'h00, 1,0,32'h0,PC,0,0,1));
    vq.push_back(mk(0,0,8'h00, 1,0,32'h0,PC,0,0,1));
    vq.push_back(mk(0,1,8'h00, 1,0,32'h0,PC,0,0,1));
    vq.push_back(mk(0,0,8'h00, 1,0,32'h0,PC,0,0,1));
    vq.push_back(mk(0,1,8'h02, 1,0,32'h0,PC,0,0,1));
    vq.push_back(mk(0,0,8'h00, 1,0,32'h0,PC,0,0,1));
    vq.push_back(mk(0,1,8'h01, 1,0,32'h0,PC,0,0,1));
    vq.push_back(mk(0,0,8'h00, 1,0,32'h0,PC,0,0,1));
    vq.push_back(mk(0,1,8'hF8, 1,0,32'h0,PC,0,0,1));
    vq.push_back(mk(0,0,8'h00, 1,0,32'h0,PC,0,0,1));
    vq.push_back(mk(0,1,8'h78, 1,0,32'h0,PC,0,0,1));
    vq.push_back(mk(0,0,8'h00, 1,0,32'h0,PC,0,0,1));
    vq.push_back(mk(0,1,8'h20, 0,1,32'h01F87820,PC,0,0,1));
    vq.push_back(mk(0,1,8'hAF, 1,0,32'h0,A4,0,0,1));
    vq.push_back(mk(0,1,8'hAF, 1,0,32'h0,A4,0,0,1));
    vq.push_back(mk(0,0,8'h00, 1,0,32'h0,A4,0,0,1));
    vq.push_back(mk(0,1,8'h0F, 1,0,32'h0,A4,0,0,1));
    vq.push_back(mk(0,0,8'h00, 1,0,32'h0,A4,0,0,1));
    vq.push_back(mk(0,1,8'h00, 1,0,32'h0,A4,0,0,1));
    vq.push_back(mk(0,0,8'h00, 1,0,32'h0,A4,0,0,1));
    vq.push_back(mk(0,1,8'h04, 0,1,32'hAF0F0004,A4,0,0,1));
    vq.push_back(mk(0,1,8'h99, 0,0,32'h0,PC,1,0,0));
    vq.push_back(mk(0,1,8'h99, 0,0,32'h0,PC,1,0,0));

    tick();
    tick();
    check("reset flags dut0", flags0(), exp_flags(0,0,0,0,1));
    check("reset addr dut0", bus0.inst_ram_write_address, PC);
    check("reset wdata dut0", bus0.inst_ram_write_data, 32'h0);
    check("reset flags dut1", flags1(), exp_flags(0,0,0,0,1));
    check("reset addr dut1", bus1.inst_ram_write_address, WPC);
    reset = 1'b0;

    for (int i = 0; i < vq.size(); i++) begin
      bus0.start      = vq[i].start;
      bus0.byte_valid = vq[i].valid;
      bus0.byte_data  = vq[i].data;
      tick();
      check($sformatf("vec%0d flags", i), flags0(),
            exp_flags(vq[i].e_ready, vq[i].e_wen, vq[i].e_done, vq[i].e_err, vq[i].e_debug));
      check($sformatf("vec%0d addr", i), bus0.inst_ram_write_address, vq[i].e_addr);
      if (vq[i].e_wen)
        check($sformatf("vec%0d wdata", i), bus0.inst_ram_write_data, vq[i].e_wdata);
    end
    bus0.start = 1'b0;
    bus0.byte_valid = 1'b0;
    check("table strobe count", n_strobe0, 4);

    // reset after two bytes of word 3 of a 5-word load
    pulse_start(0);
    send_word(0, 32'h00000005);
    send_word(0, 32'h11111111);
    send_word(0, 32'h22222222);
    send_byte(0, 8'h33);
    send_byte(0, 8'h33);
    strobes_before = n_strobe0;
    check("mid-load strobes", strobes_before, 6);
    bus0.byte_valid = 1'b1;
    bus0.byte_data  = 8'h33;
    reset = 1'b1;
    tick();
    check("mid reset flags", flags0(), exp_flags(0,0,0,0,1));
    check("mid reset addr", bus0.inst_ram_write_address, PC);
    check("mid reset wdata", bus0.inst_ram_write_data, 32'h0);
    reset = 1'b0;
    for (int k = 0; k < 6; k++) tick();
    bus0.byte_valid = 1'b0;
    check("post reset ready", {31'd0, bus0.byte_ready}, 32'd0);
    check("post reset strobes", n_strobe0, strobes_before);
    pulse_start(0);
    send_word(0, 32'h00000001);
    send_word(0, 32'h21290001);
    tick();
    check("fresh load strobes", n_strobe0, strobes_before + 1);
    check("fresh load addr", last_addr0, PC);
    check("fresh load data", last_data0, 32'h21290001);
    check("fresh load flags", flags0(), exp_flags(0,0,1,0,0));
    check("fresh load done addr", bus0.inst_ram_write_address, PC);

    // address wrap from PC_INITIAL fffffffc
    pulse_start(1);
    send_word(1, 32'h00000002);
    send_word(1, 32'h11223344);
    send_word(1, 32'h55667788);
    tick();
    check("wrap strobes", addr_q1.size(), 2);
    if (addr_q1.size() == 2) begin
      check("wrap addr0", addr_q1[0], 32'hfffffffc);
      check("wrap addr1", addr_q1[1], 32'h00000000);
      check("wrap data0", data_q1[0], 32'h11223344);
      check("wrap data1", data_q1[1], 32'h55667788);
    end
    check("wrap done flags", flags1(), exp_flags(0,0,1,0,0));
    check("wrap done addr", bus1.inst_ram_write_address, WPC);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
